// File: rtl/bilib_mem_pkg.sv
// bilib_mem_pkg: width helpers shared by the memory-port blocks
package bilib_mem_pkg;

    function automatic int addrW(input int length);
        return (length > 1) ? $clog2(length) : 1;
    endfunction

    function automatic int cntW(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered count, same-cycle push/pop honoured even when full
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write side
//   pop, head         read side; head is the oldest entry, valid while count != 0
//   count, full       occupancy
module sync_fifo
    import bilib_mem_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [cntW(DEPTH)-1:0] count,
    output logic                   full
);
    localparam int PW = addrW(DEPTH);
    localparam int CW = cntW(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && (count != '0);
    // a pop in the same cycle frees the slot, so a push at full still lands
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mem_port_initiator.sv
// mem_port_initiator: valid/ready client driver for a fixed-latency bit-masked memory port
//   clk_i, rst_i                          clock, synchronous active-high reset
//   reqValid_i/reqReady_o, reqAddr_i,
//   reqData_i, reqWr_i                    request channel (reqWr_i all zero = read)
//   rspValid_o/rspReady_i, rspData_o      in-order response channel
//   memAddr_o, memData_o, memEn_o,
//   memWr_o, memData_i                    memory port; memData_i valid DELAY cycles after memEn_o
//   outstanding_o                         in-flight plus queued responses
module mem_port_initiator
    import bilib_mem_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LENGTH    = 32,
    parameter int DELAY     = 1,
    parameter int RSP_DEPTH = 4,
    localparam int AW = addrW(LENGTH),
    localparam int CW = cntW(RSP_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             reqValid_i,
    output logic             reqReady_o,
    input  logic [AW-1:0]    reqAddr_i,
    input  logic [WIDTH-1:0] reqData_i,
    input  logic [WIDTH-1:0] reqWr_i,
    output logic             rspValid_o,
    input  logic             rspReady_i,
    output logic [WIDTH-1:0] rspData_o,
    output logic [AW-1:0]    memAddr_o,
    output logic [WIDTH-1:0] memData_o,
    output logic             memEn_o,
    output logic [WIDTH-1:0] memWr_o,
    input  logic [WIDTH-1:0] memData_i,
    output logic [CW-1:0]    outstanding_o
);
    if (DELAY < 1) begin : g_delay_chk
        $error("DELAY must be >= 1");
    end
    if (RSP_DEPTH < 1) begin : g_depth_chk
        $error("RSP_DEPTH must be >= 1");
    end

    logic [DELAY-1:0] v;
    logic             fire;
    logic             pop;
    logic             rsp_push;
    logic [CW-1:0]    fifo_count;

    // credit counts every response that will eventually occupy the FIFO,
    // so a push can never find it full
    assign reqReady_o = !rst_i && (outstanding_o < CW'(RSP_DEPTH));
    assign fire       = reqValid_i && reqReady_o;
    assign pop        = rspValid_o && rspReady_i;
    assign rsp_push   = v[0];
    assign rspValid_o = fifo_count != '0;
    assign memEn_o    = fire;
    assign memAddr_o  = reqAddr_i;
    assign memData_o  = reqData_i;
    assign memWr_o    = fire ? reqWr_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v             <= '0;
            outstanding_o <= '0;
        end else begin
            // v[0] is set in the cycle memData_i carries the response for a fire DELAY cycles earlier
            v             <= (v >> 1) | (DELAY'(fire) << (DELAY - 1));
            outstanding_o <= outstanding_o + CW'(fire) - CW'(pop);
        end
    end

    sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(RSP_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (rsp_push),
        .push_data(memData_i),
        .pop      (pop),
        .head     (rspData_o),
        .count    (fifo_count),
        .full     ()
    );

endmodule
